// File: rtl/mul_seq_radix4.sv
// ---------------------------------------------------------------------------
// mul_seq_radix4
//
// Handshaked sequential multiplier. Two WIDTH-bit operands are latched on
// acceptance, then one radix-4 digit of b is retired per cycle: the digit
// selects 0, a, 2a or 3a, which is shifted into place and added to a
// 2*WIDTH-bit accumulator. After WIDTH/2 digits the product is copied to p
// and held with out_valid until the consumer takes it.
//
// Optional feature macro: MUL_SEQ_SIGNED_EN
//   defined   -> a and b are two's complement, p is the signed product
//   undefined -> unsigned operands and product, no sign logic
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair present on a/b
//   in_ready   block can accept an operand pair this cycle
//   a          multiplicand, WIDTH bits
//   b          multiplier, WIDTH bits
//   out_valid  product available on p
//   out_ready  consumer takes the product this cycle
//   p          registered product, 2*WIDTH bits
// ---------------------------------------------------------------------------
module mul_seq_radix4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 accept;
    logic [WIDTH-1:0]     b_shift;
    logic [1:0]           digit;
    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   pp;
    logic [2*WIDTH-1:0]   step;
    logic [2*WIDTH-1:0]   acc_sum;

    // Partial product for the current digit, shifted to its weight 4^k.
    always_comb begin
        b_shift = b_q >> {cnt_q, 1'b0};
        digit   = b_shift[1:0];

`ifdef MUL_SEQ_SIGNED_EN
        a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
`else
        a_ext = {{WIDTH{1'b0}}, a_q};
`endif

        case (digit)
            2'd0:    pp = '0;
            2'd1:    pp = a_ext;
            2'd2:    pp = a_ext << 1;
            default: pp = a_ext + (a_ext << 1);
        endcase

        step = pp << {cnt_q, 1'b0};

`ifdef MUL_SEQ_SIGNED_EN
        // The top bit of b was added with weight +2^(WIDTH-1); subtracting
        // a*2^WIDTH turns that into the two's complement weight -2^(WIDTH-1).
        if (cnt_q == LAST_DIGIT && b_q[WIDTH-1]) begin
            step = step - (a_ext << WIDTH);
        end
`endif

        acc_sum = acc_q + step;
    end

    // Handshake and next-state logic. in_ready is forced low while reset is
    // asserted, and only looks at out_ready when a finished product is held.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        in_ready  = rst_n && ((state_q == IDLE) ||
                              (state_q == DONE && out_ready));
        out_valid = (state_q == DONE);
        accept    = in_valid && in_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_DIGIT) begin
                    state_d = DONE;
                    p_d     = acc_sum;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = accept ? BUSY : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new pair always restarts the digit walk from a clean accumulator.
        if (accept) begin
            a_d   = a;
            b_d   = b;
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: doc/mul_seq_radix4.md
# mul_seq_radix4

Parametrised, handshaked sequential multiplier that forms a 2·WIDTH-bit product from two WIDTH-bit operands. It retires one radix-4 digit of `b` per cycle, applying the same 2-bit partial-product decomposition as the fixed 4x4 array multiplier at any even width. It is the multiply stage feeding processing elements of the systolic array, where area matters more than single-cycle latency.

## Interface
- `WIDTH`, 8, operand width; even, ≥4
- `clk` input 1 system clock, rising edge
- `rst_n` input 1 asynchronous active-low reset
- `in_valid` input 1 operand pair present
- `in_ready` output 1 block can accept operands
- `a` input WIDTH multiplicand
- `b` input WIDTH multiplier
- `out_valid` output 1 product available
- `out_ready` input 1 consumer takes product
- `p` output 2·WIDTH product

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE, digit counter 0, accumulator 0.
- Reset values: `in_ready`=0 while `rst_n` low, 1 in IDLE afterwards; `out_valid`=0; `p`=0.
- `in_ready` = (IDLE) or (DONE and `out_ready`).
- Accept: `in_valid && in_ready` at an edge → latch `a`, `b`; clear accumulator; counter=0; go BUSY.
- BUSY, digit k (0..WIDTH/2−1): d = b[2k+1:2k]; pp = 0, a, a<<1, or a+(a<<1) for d = 0..3; acc += pp<<2k. acc is 2·WIDTH bits; no overflow possible in unsigned mode.
- After digit WIDTH/2−1 → DONE; `p` holds acc, `out_valid`=1.
- DONE: `p` and `out_valid` stable until `out_ready`=1. On `out_ready`: if `in_valid` also 1, accept the new pair and go BUSY; otherwise go IDLE.
- `in_valid` while BUSY: ignored. Operands are not held on the input.
- `rst_n` low at any time, including mid-BUSY or mid-DONE: immediate return to reset values; the partial result is discarded.
- Operand value 0 takes no shortcut; latency is fixed.

## Timing
- Latency: operands accepted at edge E0 → `out_valid` high after edge E0+WIDTH/2 (4 cycles at WIDTH=8).
- Initiation interval: WIDTH/2+1 cycles with `out_ready` tied high.
- `p` changes only on the edge entering DONE. It is a registered output with no combinational path from inputs.
- `in_ready` depends combinationally on `out_ready` in DONE only.

## Configuration
- `MUL_SEQ_SIGNED_EN` defined: `a` and `b` are two's complement.
  - `a` is sign-extended to 2·WIDTH before forming pp.
  - On the final digit, if b[WIDTH−1]=1, the step additionally subtracts a<<WIDTH, so the digit's top bit carries negative weight.
  - `p` is the signed 2·WIDTH product. Latency is unchanged.
- Not defined: unsigned operands and product; no sign logic is synthesised.

## Test plan
- WIDTH=8, unsigned, a=13, b=11, `out_ready`=1 → `out_valid` 4 cycles after accept, `p`=0x008F; then IDLE, `in_ready`=1.
- Unsigned a=0xFF, b=0xFF → `p`=0xFE01. a=0, b=0xA5 → `p`=0x0000 after the same 4-cycle latency.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `p` stable, `in_ready`=0. Raise `out_ready` with `in_valid` holding a=2, b=3 → accepted the same edge, next `p`=0x0006 four cycles later.
- `MUL_SEQ_SIGNED_EN`: a=0xFD (−3), b=0x05 → `p`=0xFFF1. a=0x80, b=0x80 → `p`=0x4000. a=0x7F, b=0x80 → `p`=0xC080.
- Assert `rst_n` low in BUSY after digit 1 → `out_valid`=0, `p`=0 immediately. After release, a=6, b=7 → `p`=0x002A with normal latency.
- Streaming 50 random pairs with random `in_valid`/`out_ready` gaps → every product matches the reference model, in order, with none dropped or duplicated.
